// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
//
// Parametrised single-clock FIFO sitting between a producer and a consumer in
// the same clock domain. It extends the older fixed 8x16 FIFO with:
//   - configurable word width and depth (power of two)
//   - a registered occupancy count
//   - almost-full / almost-empty flags with static thresholds
//   - one-cycle overflow / underflow error pulses
//   - a selectable read mode: registered read or first-word-fall-through
//
// Parameters:
//   DATA_W     data word width in bits (>= 1)
//   DEPTH      number of entries, power of two, >= 2
//   AF_THRESH  almost_full asserts when count >= AF_THRESH (<= DEPTH)
//   AE_THRESH  almost_empty asserts when count <= AE_THRESH (< DEPTH)
//   FWFT       0 = registered read (data valid the cycle after rd_en)
//              1 = first-word-fall-through (rd_en acknowledges the shown word)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   wr_en         write request
//   rd_en         read request (acknowledge in FWFT mode)
//   data_in       write data, captured when the write is accepted
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
//   data_out      read data
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic [DATA_W-1:0]          data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL    = CW'(AE_THRESH);

  // Threshold flags out of reset follow the same rule as in operation,
  // evaluated at count = 0.
  localparam logic AF_AT_ZERO = (AF_THRESH <= 0);
  localparam logic AE_AT_ZERO = (AE_THRESH >= 0);

  // Reject illegal configurations while elaborating.
  generate
    if (DATA_W < 1) begin : g_bad_data_w
      $error("sync_fifo_param: DATA_W must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH > DEPTH || AF_THRESH < 0) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must lie in 0..DEPTH");
    end
    if (AE_THRESH >= DEPTH || AE_THRESH < 0) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;
  logic [CW-1:0]     count_next;

  // A write into a full FIFO is still accepted when a read frees the slot in
  // the same cycle; a read of an empty FIFO is never accepted, even if a
  // write arrives alongside it.
  always_comb begin
    wr_ok      = wr_en & (~full | rd_en);
    rd_ok      = rd_en & ~empty;
    count_next = count + CW'(wr_ok) - CW'(rd_ok);
  end

  // Pointers, occupancy and all status flags are registered from the
  // post-edge occupancy, so the flags never depend combinationally on the
  // request inputs. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_AT_ZERO;
      almost_empty <= AE_AT_ZERO;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_LVL);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
      overflow     <= wr_en & ~wr_ok;
      underflow    <= rd_en & ~rd_ok;
    end
  end

  // Storage array is deliberately left out of reset; stale contents are
  // unreachable because reset clears both pointers and the count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (FWFT == 1'b0) begin : g_registered_read
      // The read data register loads on an accepted read only, so a rejected
      // read leaves the previous word on the output.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out <= '0;
        end else if (rd_ok) begin
          data_out <= mem[rd_ptr];
        end
      end
    end else begin : g_fwft_read
      // The head word is shown directly; forcing zero while empty keeps stale
      // memory from leaking onto the output.
      always_comb begin
        data_out = empty ? '0 : mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Exercises two instances of sync_fifo_param sharing one clock and reset:
//   dut_a : DATA_W=8,  DEPTH=16, FWFT=0 (registered read)
//   dut_b : DATA_W=12, DEPTH=4,  FWFT=1 (first-word-fall-through)
// Each instance is shadowed by a queue-based reference model; a compare
// process per instance checks every output on every falling edge, and a
// directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

  logic        clk;
  logic        rst;

  logic        wr_a, rd_a;
  logic [7:0]  din_a;
  logic        full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [4:0]  count_a;
  logic [7:0]  dout_a;

  logic        wr_b, rd_b;
  logic [11:0] din_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [2:0]  count_b;
  logic [11:0] dout_b;

  int check_count = 0;
  int pass_count  = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .data_in(din_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .count(count_a), .overflow(ovf_a), .underflow(udf_a), .data_out(dout_a)
  );

  sync_fifo_param #(.DATA_W(12), .DEPTH(4), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .data_in(din_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .count(count_b), .overflow(ovf_b), .underflow(udf_b), .data_out(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference models: a queue holds the stored words in arrival order.
  logic [7:0]  qa[$];
  logic [11:0] qb[$];
  logic [7:0]  exp_dout_a;
  logic        exp_ovf_a, exp_udf_a, exp_ovf_b, exp_udf_b;
  bit          acc_wr_a, acc_rd_a, acc_wr_b, acc_rd_b;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      exp_dout_a = '0;
      exp_ovf_a  = 1'b0;
      exp_udf_a  = 1'b0;
      exp_ovf_b  = 1'b0;
      exp_udf_b  = 1'b0;
    end else begin
      acc_wr_a  = wr_a && (qa.size() < 16 || rd_a);
      acc_rd_a  = rd_a && (qa.size() > 0);
      exp_ovf_a = wr_a && !acc_wr_a;
      exp_udf_a = rd_a && !acc_rd_a;
      if (acc_rd_a) exp_dout_a = qa.pop_front();
      if (acc_wr_a) qa.push_back(din_a);

      acc_wr_b  = wr_b && (qb.size() < 4 || rd_b);
      acc_rd_b  = rd_b && (qb.size() > 0);
      exp_ovf_b = wr_b && !acc_wr_b;
      exp_udf_b = rd_b && !acc_rd_b;
      if (acc_rd_b) void'(qb.pop_front());
      if (acc_wr_b) qb.push_back(din_b);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end else begin
      pass_count++;
    end
  endtask

  // Continuous comparison against the models, away from the active edge.
  always @(negedge clk) begin
    checkOutput("a_count", 32'(count_a), 32'(qa.size()));
    checkOutput("a_full",  32'(full_a),  32'(qa.size() == 16));
    checkOutput("a_empty", 32'(empty_a), 32'(qa.size() == 0));
    checkOutput("a_afull", 32'(af_a),    32'(qa.size() >= 14));
    checkOutput("a_aempty", 32'(ae_a),   32'(qa.size() <= 2));
    checkOutput("a_ovf",   32'(ovf_a),   32'(exp_ovf_a));
    checkOutput("a_udf",   32'(udf_a),   32'(exp_udf_a));
    checkOutput("a_dout",  32'(dout_a),  32'(exp_dout_a));

    checkOutput("b_count", 32'(count_b), 32'(qb.size()));
    checkOutput("b_full",  32'(full_b),  32'(qb.size() == 4));
    checkOutput("b_empty", 32'(empty_b), 32'(qb.size() == 0));
    checkOutput("b_afull", 32'(af_b),    32'(qb.size() >= 2));
    checkOutput("b_aempty", 32'(ae_b),   32'(qb.size() <= 2));
    checkOutput("b_ovf",   32'(ovf_b),   32'(exp_ovf_b));
    checkOutput("b_udf",   32'(udf_b),   32'(exp_udf_b));
    checkOutput("b_dout",  32'(dout_b),  32'(qb.size() != 0 ? qb[0] : 12'h000));
  end

  // Drive one cycle of requests on both FIFOs, returning on the next falling
  // edge so outputs of the edge just taken are settled.
  task automatic applyStimulus(input logic wa, input logic ra, input logic [7:0] da,
                               input logic wb, input logic rb, input logic [11:0] db);
    wr_a  = wa;
    rd_a  = ra;
    din_a = da;
    wr_b  = wb;
    rd_b  = rb;
    din_b = db;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stepA(input logic wa, input logic ra, input logic [7:0] da);
    applyStimulus(wa, ra, da, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic stepB(input logic wb, input logic rb, input logic [11:0] db);
    applyStimulus(1'b0, 1'b0, 8'h00, wb, rb, db);
  endtask

  int          writes_done;
  int          cycles;
  logic        w_rand, r_rand;
  logic [7:0]  d_rand_a;
  logic [11:0] d_rand_b;

  initial begin
    rst   = 1'b1;
    wr_a  = 1'b0; rd_a = 1'b0; din_a = '0;
    wr_b  = 1'b0; rd_b = 1'b0; din_b = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    checkOutput("rst_count", 32'(count_a), 32'd0);
    checkOutput("rst_empty", 32'(empty_a), 32'd1);
    checkOutput("rst_aempty", 32'(ae_a), 32'd1);
    checkOutput("rst_full", 32'(full_a), 32'd0);
    checkOutput("rst_dout", 32'(dout_a), 32'd0);
    checkOutput("rst_ovf", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    stepA(1'b0, 1'b0, 8'h00);

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      stepA(1'b1, 1'b0, 8'(i));
      if (i == 13) checkOutput("fill_af_13", 32'(af_a), 32'd0);
      if (i == 14) checkOutput("fill_af_14", 32'(af_a), 32'd1);
    end
    checkOutput("fill_full", 32'(full_a), 32'd1);
    checkOutput("fill_count", 32'(count_a), 32'd16);

    // Overflow on a full FIFO; 0xAA must be discarded.
    stepA(1'b1, 1'b0, 8'hAA);
    checkOutput("ovf_pulse", 32'(ovf_a), 32'd1);
    checkOutput("ovf_count", 32'(count_a), 32'd16);
    stepA(1'b0, 1'b0, 8'h00);
    checkOutput("ovf_clear", 32'(ovf_a), 32'd0);

    // Drain, each word visible after its read edge.
    for (int i = 1; i <= 16; i++) begin
      stepA(1'b0, 1'b1, 8'h00);
      checkOutput("drain_data", 32'(dout_a), 32'(i));
    end
    checkOutput("drain_empty", 32'(empty_a), 32'd1);

    // Underflow: data_out holds.
    stepA(1'b0, 1'b1, 8'h00);
    checkOutput("udf_pulse", 32'(udf_a), 32'd1);
    checkOutput("udf_hold", 32'(dout_a), 32'h10);

    // Simultaneous read+write when empty.
    stepA(1'b1, 1'b1, 8'h33);
    checkOutput("rw_empty_count", 32'(count_a), 32'd1);
    checkOutput("rw_empty_udf", 32'(udf_a), 32'd1);

    // Refill, then simultaneous read+write at full.
    for (int i = 1; i <= 15; i++) stepA(1'b1, 1'b0, 8'(8'h40 + i));
    checkOutput("refill_count", 32'(count_a), 32'd16);
    stepA(1'b1, 1'b1, 8'h55);
    checkOutput("rw_full_count", 32'(count_a), 32'd16);
    checkOutput("rw_full_data", 32'(dout_a), 32'h33);
    checkOutput("rw_full_ovf", 32'(ovf_a), 32'd0);
    for (int i = 1; i <= 16; i++) stepA(1'b0, 1'b1, 8'h00);
    checkOutput("rw_full_last", 32'(dout_a), 32'h55);

    // Pointer wrap: 40 words through with occupancy kept at 5 or less.
    writes_done = 0;
    cycles      = 0;
    while (writes_done < 40 && cycles < 400) begin
      w_rand   = (qa.size() < 5) && ($urandom_range(0, 1) == 1);
      r_rand   = ($urandom_range(0, 2) == 0);
      d_rand_a = 8'($urandom);
      stepA(w_rand, r_rand, d_rand_a);
      if (w_rand) writes_done++;
      cycles++;
    end
    checkOutput("wrap_written", 32'(writes_done), 32'd40);
    repeat (6) stepA(1'b0, 1'b1, 8'h00);
    checkOutput("wrap_empty", 32'(empty_a), 32'd1);

    // FWFT instance: word falls through without a read.
    stepB(1'b1, 1'b0, 12'hABC);
    checkOutput("fwft_show", 32'(dout_b), 32'hABC);
    checkOutput("fwft_nonempty", 32'(empty_b), 32'd0);
    stepB(1'b0, 1'b1, 12'h000);
    checkOutput("fwft_ack_empty", 32'(empty_b), 32'd1);
    checkOutput("fwft_ack_zero", 32'(dout_b), 32'd0);

    // Asynchronous reset mid-fill.
    stepB(1'b1, 1'b0, 12'h111);
    stepB(1'b1, 1'b0, 12'h222);
    stepB(1'b1, 1'b0, 12'h333);
    wr_b = 1'b0;
    checkOutput("midrst_pre", 32'(count_b), 32'd3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_count", 32'(count_b), 32'd0);
    checkOutput("midrst_empty", 32'(empty_b), 32'd1);
    checkOutput("midrst_dout", 32'(dout_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stepB(1'b1, 1'b0, 12'h7E5);
    checkOutput("post_rst_word", 32'(dout_b), 32'h7E5);

    // Randomised traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      d_rand_a = 8'($urandom);
      d_rand_b = 12'($urandom);
      applyStimulus(1'($urandom), 1'($urandom), d_rand_a,
                    1'($urandom), 1'($urandom), d_rand_b);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
